// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access path.
package dmem_pkg;

    // Lane masks as produced by the decoder.
    localparam logic [3:0] SIZE_BYTE = 4'b0001;
    localparam logic [3:0] SIZE_HALF = 4'b0011;
    localparam logic [3:0] SIZE_WORD = 4'b1111;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } dmem_state_e;

    // Register write-back source codes shared with the control unit.
    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_PC4 = 2'd2,
        SRC_IMM = 2'd3
    } reg_src_e;

    // An access is illegal when its size is unknown or it crosses its natural alignment.
    function automatic logic access_illegal(input logic [3:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (size == SIZE_HALF && off[0]) bad = 1'b1;
        if (size == SIZE_WORD && off != 2'b00) bad = 1'b1;
        if (size != SIZE_BYTE && size != SIZE_HALF && size != SIZE_WORD) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data aligner: moves the addressed lane(s) to bit 0 and extends them.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] shifted;
    assign shifted = i_raw >> {i_off, 3'b000};

    // Sign- or zero-extend according to the access size; words pass straight through.
    always_comb begin
        o_data = shifted;
        case (i_size)
            SIZE_BYTE: o_data = {{24{~i_unsigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: o_data = {{16{~i_unsigned & shifted[15]}}, shifted[15:0]};
            default:   o_data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns one MEM-stage load/store into a req/gnt/rvalid
// bus transaction, stalling the pipeline until it completes or times out.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [3:0]            i_d_size,
    input  logic                  i_d_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata,
    output logic                  o_stall,
    output logic                  o_misaligned,
    output logic                  o_bus_error,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [3:0]            o_mem_be,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [31:0]           i_mem_rdata
);

    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

    dmem_state_e           state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [1:0]            off_q, off_d;
    logic [3:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  bus_error_q, bus_error_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic        access;
    logic        illegal;
    logic        timeout_hit;
    logic [3:0]  be_calc;
    logic [31:0] load_data;

    assign access      = i_mem_read | i_mem_write;
    assign illegal     = access_illegal(i_d_size, i_addr[1:0]);
    assign timeout_hit = (TO_LIM != 32'd0) && (cnt_q == TO_LIM - 32'd1);
    assign be_calc     = i_d_size << i_addr[1:0];

    dmem_load_align u_align (
        .i_raw      (i_mem_rdata),
        .i_off      (off_q),
        .i_size     (size_q),
        .i_unsigned (uns_q),
        .o_data     (load_data)
    );

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rdata_d     = rdata_q;
        bus_error_d = 1'b0;
        req_d       = req_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (access && !illegal) begin
                    state_d = REQ;
                    cnt_d   = 32'd0;
                    req_d   = 1'b1;
                    we_d    = i_mem_write;
                    be_d    = be_calc;
                    addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = i_wdata << {i_addr[1:0], 3'b000};
                    off_d   = i_addr[1:0];
                    size_d  = i_d_size;
                    uns_d   = i_d_unsigned;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    req_d   = 1'b0;
                    cnt_d   = 32'd0;
                    state_d = we_q ? DONE : WAIT_R;
                end else if (timeout_hit) begin
                    req_d       = 1'b0;
                    state_d     = DONE;
                    bus_error_d = 1'b1;
                    rdata_d     = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WAIT_R: begin
                if (i_mem_rvalid) begin
                    rdata_d = load_data;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    bus_error_d = 1'b1;
                    rdata_d     = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= 32'd0;
            off_q       <= 2'b00;
            size_q      <= 4'b0000;
            uns_q       <= 1'b0;
            rdata_q     <= 32'd0;
            bus_error_q <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            rdata_q     <= rdata_d;
            bus_error_q <= bus_error_d;
            req_q       <= req_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Stall and misalignment are combinational so the core sees them in the request cycle.
    always_comb begin
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        if (!i_rst) begin
            case (state_q)
                IDLE: begin
                    o_stall      = access & ~illegal;
                    o_misaligned = access & illegal;
                end
                REQ, WAIT_R: o_stall = 1'b1;
                default:     o_stall = 1'b0;
            endcase
        end
    end

    assign o_rdata     = rdata_q;
    assign o_bus_error = bus_error_q;
    assign o_mem_req   = req_q;
    assign o_mem_we    = we_q;
    assign o_mem_be    = be_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Testbench for dmem_access_unit: bench-side memory responder plus scoreboard.
module tb_dmem_access_unit;

    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0011;
    localparam logic [3:0] SZ_W = 4'b1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, d_unsigned;
    logic [3:0]  d_size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misaligned, bus_error;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] err_q[$];

    // clock / reset
    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_d_size     (d_size),
        .i_d_unsigned (d_unsigned),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rdata      (rdata),
        .o_stall      (stall),
        .o_misaligned (misaligned),
        .o_bus_error  (bus_error),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_be     (mem_be),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference for the extended load value.
    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [1:0] off,
                                               input logic [3:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[8*off +: 8];
        h = raw[8*off +: 16];
        if (size == SZ_B) return uns ? {24'd0, b} : {{24{b[7]}}, b};
        if (size == SZ_H) return uns ? {16'd0, h} : {{16{h[15]}}, h};
        return raw;
    endfunction

    task automatic drive_idle();
        mem_read = 1'b0; mem_write = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    // One legal access; gnt_wait < 0 means the bus never grants.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [3:0] size, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] raw, input int gnt_wait, input int rv_wait);
        logic [1:0]  off;
        logic        is_wr, to, granted, rv_done, done;
        int          exp_stall, stalls, req_n, rv_n;
        logic [31:0] e;
        off   = a[1:0];
        is_wr = wr;
        to    = (gnt_wait < 0);
        if (to) exp_stall = 1 + 4;
        else if (is_wr) exp_stall = 1 + gnt_wait + 1;
        else exp_stall = 1 + gnt_wait + 1 + rv_wait + 1;
        if (!is_wr) exp_q.push_back(to ? 32'd0 : model_load(raw, off, size, uns));
        err_q.push_back({31'd0, to});

        @(negedge clk);
        mem_read = rd; mem_write = wr; d_size = size; d_unsigned = uns;
        addr = a; wdata = wd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
        check({tag, "_misal"}, {31'd0, misaligned}, 32'd0);
        stalls = 1; req_n = 0; rv_n = 0; granted = 0; rv_done = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (mem_req) begin
                if (req_n == 0) begin
                    check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
                    check({tag, "_be"}, {28'd0, mem_be}, {28'd0, size} << off);
                    check({tag, "_we"}, {31'd0, mem_we}, {31'd0, is_wr});
                    if (is_wr) check({tag, "_wdata"}, mem_wdata, wd << (8 * off));
                end
                if (req_n == gnt_wait) begin mem_gnt = 1'b1; granted = 1; end
                req_n++;
            end else if (granted && !is_wr && !rv_done) begin
                if (rv_n == rv_wait) begin mem_rvalid = 1'b1; mem_rdata = raw; rv_done = 1; end
                rv_n++;
            end
            #1;
            if (!stall) done = 1; else stalls++;
        end
        check({tag, "_completed"}, {31'd0, done}, 32'd1);
        if (done) begin
            if (!is_wr) begin
                e = exp_q.pop_front();
                check({tag, "_rdata"}, rdata, e);
            end
            e = err_q.pop_front();
            check({tag, "_bus_err"}, {31'd0, bus_error}, e);
            check({tag, "_stall_cycles"}, stalls, exp_stall);
        end else begin
            exp_q.delete(); err_q.delete();
        end
        @(negedge clk);
        drive_idle();
        #1;
        check({tag, "_err_pulse_end"}, {31'd0, bus_error}, 32'd0);
        check({tag, "_back_idle"}, {30'd0, stall, mem_req}, 32'd0);
    endtask

    task automatic run_misaligned(input string tag, input logic [3:0] size, input logic [31:0] a);
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; d_size = size; d_unsigned = 1'b0; addr = a;
        #1;
        check({tag, "_misal"}, {31'd0, misaligned}, 32'd1);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_no_req"}, {31'd0, mem_req}, 32'd0);
        drive_idle();
    endtask

    initial begin
        logic [3:0]  sz;
        logic [31:0] a;
        logic        w;
        rst = 1'b1; drive_idle();
        d_size = SZ_W; d_unsigned = 1'b0; addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0;
        #1;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_outs", {mem_be, 28'd0} | mem_addr | mem_wdata | rdata, 32'd0);
        check("rst_flags", {29'd0, stall, bus_error, mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_access("st_byte", 1'b0, 1'b1, SZ_B, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'd0, 0, 0);
        run_access("ld_sbyte", 1'b1, 1'b0, SZ_B, 1'b0, 32'h0000_2001, 32'd0, 32'h0000_8000, 0, 0);
        run_access("ld_ubyte", 1'b1, 1'b0, SZ_B, 1'b1, 32'h0000_2001, 32'd0, 32'h0000_8000, 0, 0);
        run_access("ld_half_dly", 1'b1, 1'b0, SZ_H, 1'b0, 32'h0000_2002, 32'd0, 32'h7FFF_0000, 3, 0);

        // Reset while waiting for read data, then a stale rvalid in IDLE.
        @(negedge clk);
        mem_read = 1'b1; d_size = SZ_W; d_unsigned = 1'b0; addr = 32'h0000_4000;
        @(negedge clk);
        mem_gnt = mem_req;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("rst_mid_pre_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0; drive_idle(); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_gnt = 1'b1;
        #1;
        check("stale_rvalid", rdata, 32'd0);
        check("stale_idle", {30'd0, stall, mem_req}, 32'd0);
        mem_gnt = 1'b0;
        run_access("ld_after_rst", 1'b1, 1'b0, SZ_H, 1'b1, 32'h0000_5000, 32'd0, 32'h1234_F00D, 1, 2);

        run_misaligned("mis_word", SZ_W, 32'h0000_3002);
        run_misaligned("mis_half", SZ_H, 32'h0000_3001);
        run_misaligned("bad_size", 4'b0111, 32'h0000_3000);

        run_access("rw_both", 1'b1, 1'b1, SZ_H, 1'b0, 32'h0000_6002, 32'h0000_CAFE, 32'd0, 0, 0);
        run_access("timeout", 1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_7000, 32'd0, 32'h5555_AAAA, -1, 0);
        run_access("st_word", 1'b0, 1'b1, SZ_W, 1'b0, 32'h0000_8004, 32'h0102_0304, 32'd0, 2, 0);

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0: sz = SZ_B;
                1: sz = SZ_H;
                default: sz = SZ_W;
            endcase
            a = {$urandom_range(0, 32'hFFFF), 2'b00};
            if (sz == SZ_B) a[1:0] = 2'($urandom_range(0, 3));
            if (sz == SZ_H) a[1] = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            run_access($sformatf("rnd%0d", i), ~w, w, sz, 1'($urandom_range(0, 1)), a,
                       $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
